// File: rtl/mem_rr_scheduler_if.sv
// Bus bundle between the four requesters, the scheduler and the shared memory port.
// The scheduler connects through the slave modport; the requester/memory side uses master.
interface mem_rr_scheduler_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          req;
  logic [3:0]          req_rw;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic [3:0]          gnt;
  logic                busy;
  logic                mem_valid;
  logic                mem_rw;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req, req_rw, req_addr, req_wdata, mem_rdata,
    output ack, rdata, gnt, busy, mem_valid, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req, req_rw, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, gnt, busy, mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rr_scheduler.sv
// Round-robin sequencer giving four requesters turns on one single-port memory.
// Optional macro HIPRI_PORT0_EN: port 0 wins outright, bounded by a starvation limit.
module mem_rr_scheduler #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        win_q, win_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        lat_q, lat_d;

  logic [3:0] cand;
  logic [1:0] rr_win;
  logic [1:0] sel;

`ifdef HIPRI_PORT0_EN
  logic [2:0] hp_cnt_q, hp_cnt_d;
  logic       hp_limit;

  // After four straight port-0 wins with others waiting, port 0 sits out one round.
  assign hp_limit = (hp_cnt_q == 3'd4) && (|bus.req[3:1]);
  assign cand     = hp_limit ? (bus.req & 4'b1110) : bus.req;
  assign sel      = (bus.req[0] && !hp_limit) ? 2'd0 : rr_win;
`else
  assign cand = bus.req;
  assign sel  = rr_win;
`endif

  always_comb begin
    logic [1:0] idx;
    logic       found;
    idx    = '0;
    found  = 1'b0;
    rr_win = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && cand[idx]) begin
        rr_win = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    busy_d      = busy_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    lat_d       = lat_q;
`ifdef HIPRI_PORT0_EN
    hp_cnt_d    = hp_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          win_d       = sel;
          gnt_d       = 4'b0001 << sel;
          busy_d      = 1'b1;
          mem_valid_d = 1'b1;
          mem_rw_d    = bus.req_rw[sel];
          mem_addr_d  = bus.req_addr[sel*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.req_wdata[sel*DATA_W +: DATA_W];
          state_d     = StIssue;
`ifdef HIPRI_PORT0_EN
          if (sel == 2'd0 && (|bus.req[3:1])) begin
            hp_cnt_d = hp_cnt_q + 3'd1;
          end else begin
            hp_cnt_d = '0;
          end
`endif
        end
      end
      StIssue: begin
        lat_d   = 3'(MEM_LAT);
        state_d = StWait;
      end
      StWait: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          if (mem_rw_q) begin
            rdata_d = bus.mem_rdata;
          end
          ack_d   = gnt_q;
          state_d = StDone;
        end
      end
      StDone: begin
`ifdef HIPRI_PORT0_EN
        // Port-0 wins leave the pointer alone so ports 1..3 keep their rotation.
        if (win_q != 2'd0) begin
          rr_ptr_d = win_q + 2'd1;
        end
`else
        rr_ptr_d = win_q + 2'd1;
`endif
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      lat_q       <= '0;
`ifdef HIPRI_PORT0_EN
      hp_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      lat_q       <= lat_d;
`ifdef HIPRI_PORT0_EN
      hp_cnt_q    <= hp_cnt_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Self-checking bench for mem_rr_scheduler: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-timeline reference model.
module tb_mem_rr_scheduler;
  localparam int LAT  = 1;
  localparam int LAT4 = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_rr_scheduler_if #(.ADDR_W(8), .DATA_W(8)) mif ();
  mem_rr_scheduler_if #(.ADDR_W(8), .DATA_W(8)) mif4 ();

  mem_rr_scheduler #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif)
  );

  mem_rr_scheduler #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT4)) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (mif4)
  );

  // Memory behind the default-latency instance: one-cycle registered read.
  logic [7:0] env_mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mif.mem_valid) begin
      if (!mif.mem_rw) env_mem[mif.mem_addr] <= mif.mem_wdata;
      else             mif.mem_rdata <= env_mem[mif.mem_addr];
    end
  end

  int errors;
  int checks;
  int cyc;
  bit auto_drop;

  // Reference model: a transaction occupies cycles 1..2+LAT after the IDLE sample.
  int         m_age;
  int         m_ptr;
  int         m_hp;
  int         m_win;
  logic       m_rw;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  task automatic model_reset();
    m_age = -1; m_ptr = 0; m_hp = 0; m_win = 0;
    m_rw = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  function automatic int pick(logic [3:0] r);
    logic [3:0] c;
    c = r;
`ifdef HIPRI_PORT0_EN
    if (r[0] && !(m_hp >= 4 && r[3:1] != 3'b000)) return 0;
    if (m_hp >= 4 && r[3:1] != 3'b000) c[0] = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (c[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] r;
    r = mif.req;
    if (m_age < 0) begin
      if (r != 4'b0000) begin
        m_win   = pick(r);
`ifdef HIPRI_PORT0_EN
        if (m_win == 0 && r[3:1] != 3'b000) m_hp = m_hp + 1;
        else m_hp = 0;
`endif
        m_rw    = mif.req_rw[m_win];
        m_addr  = mif.req_addr[m_win*8 +: 8];
        m_wdata = mif.req_wdata[m_win*8 +: 8];
        if (!m_rw) ref_mem[m_addr] = m_wdata;
        m_age = 1;
      end
    end else if (m_age == 2 + LAT) begin
`ifdef HIPRI_PORT0_EN
      if (m_win != 0) m_ptr = (m_win + 1) % 4;
`else
      m_ptr = (m_win + 1) % 4;
`endif
      m_age = -1;
    end else begin
      m_age = m_age + 1;
      if (m_age == 2 + LAT && m_rw) m_rdata = ref_mem[m_addr];
    end
  endtask

  task automatic tick();
    if (reset) model_step();
    @(posedge clk);
    @(negedge clk);
    cyc = cyc + 1;
    if (auto_drop) mif.req = mif.req & ~mif.ack;
  endtask

  task automatic set_cmd(int i, logic rw, logic [7:0] a, logic [7:0] d);
    mif.req_rw[i]          = rw;
    mif.req_addr[i*8 +: 8] = a;
    mif.req_wdata[i*8 +: 8] = d;
  endtask

  task automatic wait_grant(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (mif.mem_valid) begin
        g  = mif.gnt;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ack(output logic [3:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (mif.ack != 4'b0000) begin
        a  = mif.ack;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mif.ack, mif.gnt, mif.busy, mif.mem_valid, mif.mem_rw} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctl: ack=%b gnt=%b busy=%b mv=%b rw=%b want all 0",
               mif.ack, mif.gnt, mif.busy, mif.mem_valid, mif.mem_rw);
    end
    checks++;
    if ({mif.mem_addr, mif.mem_wdata, mif.rdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0",
               mif.mem_addr, mif.mem_wdata, mif.rdata);
    end
    reset = 1'b1;
    tick();
    set_cmd(0, 1'b1, 8'h20, 8'h5A);
    mif.req = 4'b0001;
    tick();
    tick();
    // Now in the wait phase; abort asynchronously.
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({mif.ack, mif.gnt, mif.busy, mif.mem_valid} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset_ctl: ack=%b gnt=%b busy=%b mv=%b want 0",
               mif.ack, mif.gnt, mif.busy, mif.mem_valid);
    end
    checks++;
    if (mif.mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_addr: got %h want 00", mif.mem_addr);
    end
    mif.req = 4'b0000;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (mif.busy !== 1'b0 || mif.gnt !== 4'b0000 || mif.ack !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_idle: busy=%b gnt=%b ack=%b want 0 0000 0000",
                 mif.busy, mif.gnt, mif.ack);
      end
    end
  endtask

`ifdef HIPRI_PORT0_EN
  task automatic test_hipri();
    int         order [6] = '{0, 0, 0, 0, 1, 0};
    logic [3:0] g;
    logic [3:0] a;
    bit         ok;
    auto_drop = 1'b0;
    set_cmd(0, 1'b1, 8'h01, 8'h00);
    set_cmd(1, 1'b1, 8'h02, 8'h00);
    mif.req = 4'b0011;
    for (int n = 0; n < 6; n++) begin
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'(1 << order[n])) begin
        errors++;
        $display("FAIL hipri_grant%0d: got %b want %b", n, g, 4'(1 << order[n]));
      end
    end
    mif.req = 4'b0000;
    wait_ack(a, ok);
    auto_drop = 1'b1;
    tick();
  endtask
`else
  task automatic test_all_four();
    int order [5] = '{0, 1, 2, 3, 0};
    int ng;
    int na;
    int last_ack;
    ng = 0; na = 0; last_ack = 0;
    auto_drop = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 8'(i + 4), 8'h00);
    mif.req = 4'b1111;
    for (int n = 0; n < 40 && na < 5; n++) begin
      tick();
      if (mif.mem_valid) begin
        if (ng < 5) begin
          checks++;
          if (mif.gnt !== 4'(1 << order[ng])) begin
            errors++;
            $display("FAIL rr_order%0d: got %b want %b", ng, mif.gnt, 4'(1 << order[ng]));
          end
        end
        ng++;
      end
      if (mif.ack != 4'b0000) begin
        if (na > 0) begin
          checks++;
          if (cyc - last_ack != 4) begin
            errors++;
            $display("FAIL rr_ack_spacing: got %0d want 4", cyc - last_ack);
          end
        end
        last_ack = cyc;
        na++;
      end
    end
    checks++;
    if (na != 5) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d want 5", na);
    end
    mif.req = 4'b0000;
    auto_drop = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_wrap_skip();
    logic [3:0] g;
    logic [3:0] a;
    bit         ok;
    int         g1;
    set_cmd(3, 1'b0, 8'h30, 8'h33);
    set_cmd(0, 1'b0, 8'h31, 8'h44);
    mif.req = 4'b1000;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b1000) begin
      errors++; $display("FAIL wrap_first: got %b want 1000", g);
    end
    wait_ack(a, ok);
    mif.req = 4'b1001;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin
      errors++; $display("FAIL wrap_to0: got %b want 0001", g);
    end
    wait_ack(a, ok);
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b1000) begin
      errors++; $display("FAIL wrap_then3: got %b want 1000", g);
    end
    wait_ack(a, ok);
    tick();
    auto_drop = 1'b0;
    set_cmd(2, 1'b1, 8'h31, 8'h00);
    mif.req = 4'b0100;
    wait_grant(g, ok);
    g1 = cyc;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b0100 || cyc - g1 != 4) begin
      errors++;
      $display("FAIL lone_b2b: got %b gap %0d want 0100 gap 4", g, cyc - g1);
    end
    mif.req = 4'b0000;
    wait_ack(a, ok);
    auto_drop = 1'b1;
    tick();
  endtask
`endif

  task automatic test_single_wr_rd();
    tick();
    set_cmd(0, 1'b0, 8'h10, 8'hA5);
    mif.req = 4'b0001;
    tick();
    checks++;
    if (mif.mem_valid !== 1'b1 || mif.mem_addr !== 8'h10 || mif.mem_wdata !== 8'hA5 ||
        mif.mem_rw !== 1'b0) begin
      errors++;
      $display("FAIL wr_issue: mv=%b addr=%h wd=%h rw=%b want 1 10 a5 0",
               mif.mem_valid, mif.mem_addr, mif.mem_wdata, mif.mem_rw);
    end
    tick();
    checks++;
    if (mif.mem_valid !== 1'b0 || mif.ack !== 4'b0000) begin
      errors++;
      $display("FAIL wr_wait: mv=%b ack=%b want 0 0000", mif.mem_valid, mif.ack);
    end
    tick();
    checks++;
    if (mif.ack !== 4'b0001) begin
      errors++; $display("FAIL wr_ack: got %b want 0001", mif.ack);
    end
    tick();
    set_cmd(0, 1'b1, 8'h10, 8'h00);
    mif.req = 4'b0001;
    tick();
    tick();
    tick();
    checks++;
    if (mif.ack !== 4'b0001 || mif.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_ack: ack=%b rdata=%h want 0001 a5", mif.ack, mif.rdata);
    end
    tick();
  endtask

  task automatic test_withdraw();
    logic [3:0] g;
    logic [3:0] a;
    bit         ok;
    int         nv;
    tick();
    set_cmd(1, 1'b0, 8'h44, 8'h99);
    mif.req = 4'b0010;
    wait_grant(g, ok);
    mif.req = 4'b0000;
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0010) begin
      errors++; $display("FAIL withdraw_ack: got %b want 0010", a);
    end
    nv = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (mif.mem_valid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++; $display("FAIL withdraw_regrant: got %0d issues want 0", nv);
    end
  endtask

  task automatic test_lat4();
    int         vcyc;
    int         n;
    bit         got;
    logic [7:0] exp_rd;
    vcyc = -100; got = 1'b0; exp_rd = '0;
    mif4.req_rw            = 4'b0100;
    mif4.req_addr[23:16]   = 8'h33;
    mif4.req               = 4'b0100;
    for (n = 1; n <= 20; n++) begin
      tick();
      mif4.mem_rdata = 8'($urandom);
      if (mif4.mem_valid) vcyc = n;
      if (n == vcyc + LAT4) exp_rd = mif4.mem_rdata;
      if (mif4.ack != 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
    mif4.req = 4'b0000;
    checks++;
    if (!got || n != 2 + LAT4 || mif4.ack !== 4'b0100) begin
      errors++;
      $display("FAIL lat4_latency: got %0d cycles ack=%b want 6 0100", n, mif4.ack);
    end
    checks++;
    if (mif4.rdata !== exp_rd) begin
      errors++; $display("FAIL lat4_rdata: got %h want %h", mif4.rdata, exp_rd);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    logic [3:0] exp_ack;
    auto_drop = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!mif.req[i] && $urandom_range(0, 3) == 0) begin
          set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
          mif.req[i] = 1'b1;
        end
      end
      tick();
      exp_gnt = (m_age > 0) ? 4'(1 << m_win) : 4'b0000;
      exp_ack = (m_age == 2 + LAT) ? exp_gnt : 4'b0000;
      checks++;
      if (mif.gnt !== exp_gnt) begin
        errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, mif.gnt, exp_gnt);
      end
      checks++;
      if (mif.ack !== exp_ack) begin
        errors++; $display("FAIL rnd_ack c%0d: got %b want %b", c, mif.ack, exp_ack);
      end
      checks++;
      if (mif.busy !== (m_age > 0)) begin
        errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, mif.busy, m_age > 0);
      end
      checks++;
      if (mif.mem_valid !== (m_age == 1)) begin
        errors++;
        $display("FAIL rnd_mem_valid c%0d: got %b want %b", c, mif.mem_valid, m_age == 1);
      end
      checks++;
      if (mif.mem_rw !== m_rw || mif.mem_addr !== m_addr || mif.mem_wdata !== m_wdata) begin
        errors++;
        $display("FAIL rnd_cmd c%0d: got %b %h %h want %b %h %h", c, mif.mem_rw,
                 mif.mem_addr, mif.mem_wdata, m_rw, m_addr, m_wdata);
      end
      checks++;
      if (mif.rdata !== m_rdata) begin
        errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, mif.rdata, m_rdata);
      end
    end
    mif.req = 4'b0000;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; auto_drop = 1'b1;
    mif.req = '0; mif.req_rw = '0; mif.req_addr = '0; mif.req_wdata = '0;
    mif4.req = '0; mif4.req_rw = '0; mif4.req_addr = '0; mif4.req_wdata = '0;
    mif4.mem_rdata = '0;
    model_reset();
    test_reset();
`ifdef HIPRI_PORT0_EN
    test_hipri();
`else
    test_all_four();
    test_wrap_skip();
`endif
    test_single_wr_rd();
    test_withdraw();
    test_lat4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
